// File: rtl/seq_gen.sv
// Serial pattern generator: shifts a latched pattern out MSB-first,
// with a programmable repeat count and idle gap between repetitions.
module seq_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             abort,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(PAT_W);
  localparam logic [REP_W:0]   R_ONE = (REP_W+1)'(1);
  localparam logic [GAP_W-1:0] G_ONE = GAP_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [REP_W:0]   rep_tot;
  logic [REP_W:0]   rep_i;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_i;

  logic [LEN_W-1:0] len_eff;
  logic [REP_W:0]   rep_eff;

  // Out-of-range length and zero repeat fall back to full / single.
  always_comb begin
    len_eff = pat_len;
    if (pat_len == '0 || pat_len > L_MAX)
      len_eff = L_MAX;
    rep_eff = {1'b0, rep_cnt};
    if (rep_cnt == '0)
      rep_eff = R_ONE;
  end

  function automatic logic pick(
    input logic [PAT_W-1:0] p,
    input logic [LEN_W-1:0] i
  );
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pat_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      rep_tot  <= '0;
      rep_i    <= '0;
      gap_q    <= '0;
      gap_i    <= '0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          dout     <= 1'b0;
          dout_vld <= 1'b0;
          busy     <= 1'b0;
          if (start && !abort) begin
            pat_q    <= pattern;
            len_q    <= len_eff;
            rep_tot  <= rep_eff;
            gap_q    <= gap_len;
            rep_i    <= R_ONE;
            idx      <= len_eff - L_ONE;
            dout     <= pick(pattern, len_eff - L_ONE);
            dout_vld <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            state    <= IDLE;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
          end else if (idx != '0) begin
            idx  <= idx - L_ONE;
            dout <= pick(pat_q, idx - L_ONE);
          end else if (rep_i < rep_tot) begin
            if (gap_q != '0) begin
              state    <= GAP;
              gap_i    <= gap_q - G_ONE;
              dout     <= 1'b0;
              dout_vld <= 1'b0;
            end else begin
              rep_i <= rep_i + R_ONE;
              idx   <= len_q - L_ONE;
              dout  <= pick(pat_q, len_q - L_ONE);
            end
          end else begin
            state    <= IDLE;
            dout     <= 1'b0;
            dout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (gap_i == '0) begin
            state    <= SEND;
            rep_i    <= rep_i + R_ONE;
            idx      <= len_q - L_ONE;
            dout     <= pick(pat_q, len_q - L_ONE);
            dout_vld <= 1'b1;
          end else begin
            gap_i <= gap_i - G_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          dout     <= 1'b0;
          dout_vld <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
